// File: rtl/afe_pkg.sv
// Shared types and slot-geometry helpers for the AFE RX I/Q packer.
package afe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_Q = 2'd2
    } afe_state_e;

    localparam int SAMPLE_W_DEF = 12;

    // Width of one assembled I/Q pair.
    function automatic int iq_pair_w(input int sample_w);
        return 2 * sample_w;
    endfunction

    // Bit offset of pair slot idx inside a packed output word.
    function automatic int afe_pack_slot(input int idx, input int sample_w);
        return idx * iq_pair_w(sample_w);
    endfunction

endpackage

// File: rtl/afe_fifo2.sv
// Two-entry synchronous FIFO; head is presented combinationally on dout.
module afe_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        cnt_q;
    logic              do_pop;
    logic              do_push;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    assign do_pop  = pop & (cnt_q != 2'd0);
    assign do_push = push & ((cnt_q != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= din;
                    end else begin
                        tail_q <= din;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign dout  = head_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/afe_rx_iq_packer.sv
// AFE RX capture: pairs interleaved I/Q samples, packs PACK pairs per word, buffers two words.
//
//  state  | meaning
//  IDLE   | capture disabled, partial word cleared
//  WAIT_I | expecting an I-phase sample (rx_sel=1)
//  WAIT_Q | I latched, expecting the matching Q sample (rx_sel=0)
module afe_rx_iq_packer
    import afe_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int PACK     = 2,
    parameter int CNT_W    = 16
) (
    input  logic                       sclk_2x,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       iq_swap,
    input  logic                       clr,
    input  logic [SAMPLE_W-1:0]        rx_d,
    input  logic                       rx_sel,
    output logic [PACK*2*SAMPLE_W-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic                       sync_err
);

    localparam int PAIR_W = iq_pair_w(SAMPLE_W);
    localparam int WORD_W = PACK * PAIR_W;
    localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

    afe_state_e        state;
    afe_state_e        state_nxt;
    logic [SAMPLE_W-1:0] i_q;
    logic [SAMPLE_W-1:0] i_nxt;
    logic [WORD_W-1:0] pack_q;
    logic [WORD_W-1:0] pack_nxt;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_nxt;
    logic              seen_q;
    logic              seen_nxt;
    logic [PAIR_W-1:0] pair;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              err_set;
    logic              overflow;

    always_comb begin
        state_nxt = state;
        i_nxt     = i_q;
        pack_nxt  = pack_q;
        idx_nxt   = idx_q;
        seen_nxt  = seen_q;
        push      = 1'b0;
        err_set   = 1'b0;
        pair      = iq_swap ? {i_q, rx_d} : {rx_d, i_q};
        word      = pack_q;
        word[afe_pack_slot(int'(idx_q), SAMPLE_W) +: PAIR_W] = pair;

        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            pack_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_I;
                    seen_nxt  = 1'b0;
                end
                WAIT_I: begin
                    if (rx_sel) begin
                        i_nxt     = rx_d;
                        state_nxt = WAIT_Q;
                    end else begin
                        // A missing I only counts as a slip once the stream has locked.
                        err_set = seen_q;
                    end
                end
                WAIT_Q: begin
                    if (rx_sel) begin
                        i_nxt   = rx_d;
                        err_set = 1'b1;
                    end else begin
                        state_nxt = WAIT_I;
                        seen_nxt  = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            push     = 1'b1;
                            pack_nxt = '0;
                            idx_nxt  = '0;
                        end else begin
                            pack_nxt = word;
                            idx_nxt  = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign pop      = out_valid & out_ready;
    assign overflow = push & full & ~pop;

    always_ff @(posedge sclk_2x or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            i_q      <= '0;
            pack_q   <= '0;
            idx_q    <= '0;
            seen_q   <= 1'b0;
            ovf_cnt  <= '0;
            sync_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            i_q    <= i_nxt;
            pack_q <= pack_nxt;
            idx_q  <= idx_nxt;
            seen_q <= seen_nxt;
            if (clr) begin
                ovf_cnt  <= '0;
                sync_err <= 1'b0;
            end else begin
                if (err_set) begin
                    sync_err <= 1'b1;
                end
                if (overflow && (ovf_cnt != '1)) begin
                    ovf_cnt <= ovf_cnt + CNT_W'(1);
                end
            end
        end
    end

    afe_fifo2 #(
        .DATA_W (WORD_W)
    ) u_fifo (
        .clk     (sclk_2x),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (word),
        .dout    (out_data),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid = ~empty;

endmodule
